// File: rtl/pkt_dl_pkg.sv
// Shared types and widths for the packet-handler deadlock reporter.
// Pure declarations: no logic, no latency.
// No flow control; consumers import what they need.
package pkt_dl_pkg;

    // Reporter FSM: waiting for a stall, counting a stall run, latched deadlock.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SUSPECT = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam int INFO_W_DEFAULT = 4;
    localparam int EVT_W          = 16;

endpackage

// File: rtl/pkt_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
// Latency: count reflects inc/clr one cycle after the sampling edge.
// No backpressure; inc is ignored once saturated, clr wins over inc.
module pkt_sat_counter #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    // Count up until all-ones, then hold; reset and clear both zero it.
    always_ff @(posedge clock) begin
        if (reset || clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/packet_handler_deadlock_reporter.sv
// Filters monitor block indications into a sticky deadlock flag, irq pulse and stats.
// Latency: deadlock/irq registered, visible after the THRESHOLD-th consecutive block edge.
// No backpressure: block_in sampled every cycle; clear is a one-cycle software strobe.
module packet_handler_deadlock_reporter
    import pkt_dl_pkg::*;
#(
    parameter int INFO_W    = INFO_W_DEFAULT,
    parameter int THRESHOLD = 1024,
    parameter int CNT_W     = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              block_in,
    input  logic [INFO_W-1:0] axis_block_info_in,
    input  logic              clear,
    output logic              deadlock,
    output logic              deadlock_irq,
    output logic [INFO_W-1:0] deadlock_info,
    output logic              recovered,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [EVT_W-1:0]  event_count,
    output logic [EVT_W-1:0]  transient_count
);

    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(THRESHOLD - 1);

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  run_cnt;
    logic [INFO_W-1:0] info_acc;
    logic              run_inc;
    logic              run_clr;
    logic              stall_inc;
    logic              confirm;
    logic              trans_inc;

    // Next state and counter strobes; clear overrides every transition.
    always_comb begin
        state_nxt = state;
        run_inc   = 1'b0;
        run_clr   = 1'b0;
        stall_inc = 1'b0;
        confirm   = 1'b0;
        trans_inc = 1'b0;
        if (clear) begin
            state_nxt = IDLE;
            run_clr   = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (block_in) begin
                        state_nxt = SUSPECT;
                        run_inc   = 1'b1;
                    end
                end
                SUSPECT: begin
                    if (!block_in) begin
                        state_nxt = IDLE;
                        run_clr   = 1'b1;
                        trans_inc = 1'b1;
                    end else if (run_cnt == RUN_LAST) begin
                        state_nxt = LOCKED;
                        run_clr   = 1'b1;
                        confirm   = 1'b1;
                    end else begin
                        run_inc = 1'b1;
                    end
                end
                LOCKED: begin
                    stall_inc = block_in;
                end
                default: begin
                    state_nxt = IDLE;
                    run_clr   = 1'b1;
                end
            endcase
        end
    end

    // State register plus the sticky flags and channel-info accumulation.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            info_acc      <= '0;
            deadlock      <= 1'b0;
            deadlock_irq  <= 1'b0;
            deadlock_info <= '0;
            recovered     <= 1'b0;
        end else if (clear) begin
            state         <= IDLE;
            info_acc      <= '0;
            deadlock      <= 1'b0;
            deadlock_irq  <= 1'b0;
            deadlock_info <= '0;
            recovered     <= 1'b0;
        end else begin
            state        <= state_nxt;
            deadlock_irq <= confirm;
            if (confirm) begin
                deadlock      <= 1'b1;
                deadlock_info <= info_acc | axis_block_info_in;
                info_acc      <= '0;
            end else if (state == IDLE && block_in) begin
                info_acc <= axis_block_info_in;
            end else if (state == SUSPECT) begin
                info_acc <= block_in ? (info_acc | axis_block_info_in) : '0;
            end else if (state == LOCKED) begin
                if (block_in) begin
                    deadlock_info <= deadlock_info | axis_block_info_in;
                end else begin
                    recovered <= 1'b1;
                end
            end
        end
    end

    pkt_sat_counter #(.W(CNT_W)) u_run_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (run_inc),
        .clr   (run_clr),
        .count (run_cnt)
    );

    pkt_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (stall_inc),
        .clr   (clear),
        .count (stall_cycles)
    );

    pkt_sat_counter #(.W(EVT_W)) u_event_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (confirm),
        .clr   (1'b0),
        .count (event_count)
    );

    pkt_sat_counter #(.W(EVT_W)) u_trans_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (trans_inc),
        .clr   (1'b0),
        .count (transient_count)
    );

endmodule

// File: tb/tb_packet_handler_deadlock_reporter.sv
// Bench for the deadlock reporter: run-length reference model compared every cycle.
// Latency: model updated on each rising edge, outputs compared on the falling edge.
// No backpressure; inputs are driven on the falling edge after comparison.
module tb_packet_handler_deadlock_reporter;

    localparam int INFO_W = 4;
    localparam int THR    = 8;
    localparam int CW     = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic              block_in;
    logic [INFO_W-1:0] axis_block_info_in;
    logic              clear;
    logic              deadlock;
    logic              deadlock_irq;
    logic [INFO_W-1:0] deadlock_info;
    logic              recovered;
    logic [CW-1:0]     stall_cycles;
    logic [15:0]       event_count;
    logic [15:0]       transient_count;

    // Small standalone counter for the saturation corner.
    logic       sc_inc;
    logic       sc_clr;
    logic [3:0] sc_count;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Reference model state: length of the current stall run and latched results.
    int          m_run;
    logic [3:0]  m_acc;
    bit          m_locked;
    logic        m_dl;
    logic        m_irq;
    logic [3:0]  m_info;
    logic        m_rec;
    int          m_stall;
    int          m_ev;
    int          m_tr;

    always #5 clock = ~clock;

    packet_handler_deadlock_reporter #(
        .INFO_W    (INFO_W),
        .THRESHOLD (THR),
        .CNT_W     (CW)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .block_in           (block_in),
        .axis_block_info_in (axis_block_info_in),
        .clear              (clear),
        .deadlock           (deadlock),
        .deadlock_irq       (deadlock_irq),
        .deadlock_info      (deadlock_info),
        .recovered          (recovered),
        .stall_cycles       (stall_cycles),
        .event_count        (event_count),
        .transient_count    (transient_count)
    );

    pkt_sat_counter #(.W(4)) u_sc (
        .clock (clock),
        .reset (reset),
        .inc   (sc_inc),
        .clr   (sc_clr),
        .count (sc_count)
    );

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: count consecutive blocked samples; the THR-th one confirms.
    always @(posedge clock) begin
        if (reset) begin
            m_run = 0; m_acc = '0; m_locked = 0; m_dl = 0; m_irq = 0;
            m_info = '0; m_rec = 0; m_stall = 0; m_ev = 0; m_tr = 0;
        end else if (clear) begin
            m_run = 0; m_acc = '0; m_locked = 0; m_dl = 0; m_irq = 0;
            m_info = '0; m_rec = 0; m_stall = 0;
        end else begin
            m_irq = 0;
            if (m_locked) begin
                if (block_in) begin
                    m_stall = (m_stall >= (1 << CW) - 1) ? m_stall : m_stall + 1;
                    m_info  = m_info | axis_block_info_in;
                end else begin
                    m_rec = 1;
                end
            end else if (block_in) begin
                m_run = m_run + 1;
                m_acc = m_acc | axis_block_info_in;
                if (m_run == THR) begin
                    m_locked = 1; m_dl = 1; m_irq = 1; m_info = m_acc;
                    m_ev = (m_ev >= 16'hFFFF) ? m_ev : m_ev + 1;
                    m_run = 0; m_acc = '0;
                end
            end else if (m_run > 0) begin
                m_tr = (m_tr >= 16'hFFFF) ? m_tr : m_tr + 1;
                m_run = 0; m_acc = '0;
            end
        end
    end

    // Every-cycle comparison of all DUT outputs against the model.
    always @(negedge clock) begin
        if (cmp_en) begin
            check("deadlock",        deadlock,        m_dl);
            check("deadlock_irq",    deadlock_irq,    m_irq);
            check("deadlock_info",   deadlock_info,   m_info);
            check("recovered",       recovered,       m_rec);
            check("stall_cycles",    stall_cycles,    m_stall);
            check("event_count",     event_count,     m_ev);
            check("transient_count", transient_count, m_tr);
        end
    end

    // One sampling edge with the given inputs; returns on the following falling edge.
    task automatic step(input bit blk, input logic [3:0] inf, input bit clr, input bit rst);
        block_in           = blk;
        axis_block_info_in = inf;
        clear              = clr;
        reset              = rst;
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        reset = 1'b1; block_in = 1'b0; axis_block_info_in = '0; clear = 1'b0;
        sc_inc = 1'b0; sc_clr = 1'b0;
        @(negedge clock);
        step(0, 4'h0, 0, 1);
        step(0, 4'h0, 0, 1);
        cmp_en = 1'b1;
        check("reset_deadlock", deadlock, 0);
        check("reset_event", event_count, 0);
        check("reset_info", deadlock_info, 0);

        // Confirmation with split channel info.
        for (int i = 0; i < 4; i++) step(1, 4'b0010, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 4'b1000, 0, 0);
        check("pre_confirm_dl", deadlock, 0);
        step(1, 4'b1000, 0, 0);
        check("confirm_dl", deadlock, 1);
        check("confirm_irq", deadlock_irq, 1);
        check("confirm_info", deadlock_info, 4'b1010);
        check("confirm_event", event_count, 1);
        check("confirm_stall", stall_cycles, 0);
        for (int i = 0; i < 5; i++) step(1, 4'h0, 0, 0);
        check("irq_one_cycle", deadlock_irq, 0);
        check("stall_five", stall_cycles, 5);
        step(0, 4'h0, 0, 0);
        check("recovered", recovered, 1);
        check("dl_sticky", deadlock, 1);
        step(1, 4'h1, 0, 0);
        check("recovered_sticky", recovered, 1);
        step(0, 4'h0, 1, 0);
        check("clear_dl", deadlock, 0);
        check("clear_info", deadlock_info, 0);
        check("clear_rec", recovered, 0);
        check("clear_keeps_event", event_count, 1);

        // Seven-cycle stall is only transient.
        for (int i = 0; i < 7; i++) step(1, 4'h4, 0, 0);
        step(0, 4'h0, 0, 0);
        check("transient_dl", deadlock, 0);
        check("transient_count", transient_count, 1);

        // Clear on the would-be confirming edge.
        for (int i = 0; i < 7; i++) step(1, 4'h4, 0, 0);
        step(1, 4'h4, 1, 0);
        step(0, 4'h0, 0, 0);
        check("clr_confirm_dl", deadlock, 0);
        check("clr_confirm_event", event_count, 1);
        check("clr_confirm_trans", transient_count, 1);

        // Reset mid-SUSPECT, then a clean confirmation.
        for (int i = 0; i < 3; i++) step(1, 4'h2, 0, 0);
        step(1, 4'h2, 0, 1);
        check("rst_event", event_count, 0);
        check("rst_trans", transient_count, 0);
        for (int i = 0; i < 8; i++) step(1, 4'h1, 0, 0);
        check("post_rst_dl", deadlock, 1);
        check("post_rst_event", event_count, 1);

        // Stall counter saturates at 4'hF.
        for (int i = 0; i < 20; i++) step(1, 4'h0, 0, 0);
        check("stall_sat", stall_cycles, 4'hF);
        step(0, 4'h0, 1, 0);

        // Standalone counter saturation and clear.
        sc_inc = 1'b1;
        for (int i = 0; i < 20; i++) step(0, 4'h0, 0, 0);
        check("sat_counter_hold", sc_count, 4'hF);
        sc_inc = 1'b0; sc_clr = 1'b1;
        step(0, 4'h0, 0, 0);
        check("sat_counter_clr", sc_count, 0);
        sc_clr = 1'b0;

        // Randomized run lengths, clears and occasional reset.
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 9) < 8), 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 39) == 0), ($urandom_range(0, 399) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/packet_handler_deadlock_reporter.md
# packet_handler_deadlock_reporter

Downstream consumer of the packet-handler dataflow deadlock monitor. Filters its per-cycle `block` and `axis_block_info` outputs through a consecutive-cycle threshold, promotes a persistent stall to a sticky, software-clearable deadlock flag with a one-cycle interrupt pulse, and accumulates which AXIS channels were blocking. Keeps saturating statistics (confirmed events, transient stalls, stall duration) for debug readout.

## Interface
- `INFO_W`, 4, width of the per-channel block info vector (2 bits per AXIS channel).
- `THRESHOLD`, 1024, consecutive `block_in` cycles needed to confirm a deadlock; legal range 2..2^CNT_W-1.
- `CNT_W`, 32, width of run counter and `stall_cycles`.
- `clock` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `block_in` in 1: monitor block indication, sampled every cycle.
- `axis_block_info_in` in INFO_W: monitor channel info, valid when `block_in`=1.
- `clear` in 1: single-cycle software clear of the sticky state.
- `deadlock` out 1: sticky confirmed-deadlock flag.
- `deadlock_irq` out 1: one-cycle pulse on confirmation.
- `deadlock_info` out INFO_W: OR of `axis_block_info_in` over the confirmed window.
- `recovered` out 1: `block_in` fell after confirmation, before clear.
- `stall_cycles` out CNT_W: cycles `block_in`=1 while LOCKED, saturating.
- `event_count` out 16: confirmed deadlocks since reset, saturating.
- `transient_count` out 16: stall episodes that ended before THRESHOLD, saturating.

## Operation
- FSM states IDLE, SUSPECT, LOCKED; all outputs registered.
- IDLE: `block_in`=1 -> SUSPECT, run_cnt<=1, info_acc<=`axis_block_info_in`.
- SUSPECT, `block_in`=0 -> IDLE, run_cnt<=0, info_acc<=0, `transient_count`+1.
- SUSPECT, `block_in`=1, run_cnt<THRESHOLD-1 -> run_cnt+1, info_acc|=input.
- SUSPECT, `block_in`=1, run_cnt==THRESHOLD-1 -> LOCKED; `deadlock`<=1, `deadlock_irq`<=1, `deadlock_info`<=info_acc|input, `event_count`+1.
- LOCKED: stays until `clear`. `block_in`=1 -> `stall_cycles`+1 and `deadlock_info`|=input. `block_in`=0 -> `recovered`<=1 (sticky); `block_in` returning high does not clear `recovered`.
- `clear` (any state): next state IDLE; run_cnt, info_acc, `deadlock`, `deadlock_info`, `stall_cycles`, `recovered` <=0. `event_count`/`transient_count` preserved (reset only).
- Priority: reset > clear > FSM transitions. Clear coinciding with the confirming sample: no confirmation, no irq, no count increment, no transient increment.
- Counters saturate at all-ones; no wrap.

## Timing
- Reset: all outputs 0, state IDLE.
- `block_in` high on N consecutive sampling edges, first at edge k: `deadlock` and `deadlock_irq` visible after edge k+THRESHOLD-1; `deadlock_irq` low after next edge.
- `stall_cycles` first increments on edge following confirmation.
- `clear` at edge c: outputs zero after edge c; a `block_in`=1 at edge c+1 starts a new SUSPECT window.
- Single-cycle gap in `block_in` during SUSPECT restarts the window (transient counted).

## Structure
- Shared package `pkt_dl_pkg`: state enum (IDLE/SUSPECT/LOCKED), default INFO_W, event counter width 16.
- Sub-module `pkt_sat_counter` (parameter W; inc, clr, count out, saturating) instantiated for run_cnt, `stall_cycles`, `event_count`, `transient_count`.

## Test plan
- THRESHOLD=8: `block_in` high 8 cycles, info 4'b0010 x4 then 4'b1000 x4 -> `deadlock`=1 after 8th edge, `deadlock_irq` one cycle, `deadlock_info`=4'b1010, `event_count`=1.
- `block_in` high 7 cycles then low -> `deadlock`=0, no irq, `transient_count`=1, state IDLE.
- LOCKED, 5 more high cycles, then low -> `stall_cycles`=5, `recovered`=1, `deadlock` stays 1; `clear` -> all sticky outputs 0, `event_count` still 1.
- `clear` asserted on the 8th consecutive high edge -> no `deadlock`, no irq, `event_count` and `transient_count` unchanged.
- Force 65537 transient episodes (or preload) -> `transient_count` holds 16'hFFFF.
- `reset` asserted on 4th high cycle of SUSPECT -> all outputs 0; subsequent 8 high cycles confirm normally.
